decode_wide: RTL and testbench
==============================

# decode_wide

Parametrised N-wide decode stage between fetch (FE1) and rename (RN0). Each cycle it decodes up to NDEC raw instructions into `t_uinstr` micro-ops in DE0 and pushes them in program order into an internal DEPTH-entry uop queue. Rename drains the queue up to NPOP entries per cycle in DE1. The queue flushes on nuke, and the block stops accepting instructions after an EBREAK.

## Interface
Parameters:
- NDEC, 2: decode lanes per cycle; lane 0 is oldest.
- NPOP, 2: maximum uops popped to rename per cycle.
- DEPTH, 8: uop queue entries. Legal only when DEPTH >= NDEC and DEPTH >= NPOP; elaboration error otherwise.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- nuke_rb1  in  t_nuke_pkt  flush request; only `.valid` is used.
- valid_fe1  in  NDEC  per-lane valid; must be contiguous from lane 0.
- instr_fe1  in  NDEC x t_instr_pkt  raw instruction, pc and SIMID per lane.
- decode_ready_de0  out  1  block can accept a full NDEC-wide bundle this cycle.
- rename_ready_rn0  in  1  rename accepts pops this cycle.
- valid_de1  out  NPOP  per-slot pop valid; contiguous from slot 0.
- uinstr_de1  out  NPOP x t_uinstr  popped uops; slot 0 is oldest.
- occupancy_de  out  $clog2(DEPTH+1)  current number of queue entries.
- ebreak_hold_de  out  1  EBREAK latched; further fetch input is discarded.

## Operation
- **Bundle acceptance**
  - decode_ready_de0 = ~reset & (DEPTH − occupancy_de >= NDEC).
  - A bundle is accepted iff decode_ready_de0 & |valid_fe1. Fetch must hold its inputs while decode_ready_de0 = 0.
- **Per-lane decode** (pc, opcode, ifmt from `get_instr_format`, uop from `rv_instr_to_uop`):
  - R: funct7, funct3; dst, src1, src2 are OP_REG. opsize is SZ_4B when opcode[3] = 1, else SZ_8B. imm64 = 0.
  - I: funct3. If the opcode is an ALU opcode, dst and src1 are OP_REG and src2 is OP_IMM, with opsize per opcode[3] as for R. For any other I opcode, dst = rd as OP_REG and src1 = rs1 as OP_REG, both SZ_8B. imm64 = sext(imm[11:0]).
  - S: src1 = rs1, src2 = rs2, both OP_REG SZ_8B; dst is OP_INVD. imm64 = sext({imm_11_5, imm_4_0}).
  - B: src1 and src2 are OP_REG SZ_4B; dst is OP_INVD. imm64 = sext({imm_12, imm_11, imm_10_5, imm_4_1, 0}), 13 bits.
  - U: dst = rd as OP_REG SZ_8B. imm64 = sext64({imm_31_12, 12'b0}).
  - J: dst = rd as OP_REG SZ_8B. imm64 = sext({imm_20, imm_19_12, imm_11, imm_10_1, 0}), 21 bits.
  - Register-zero rule: a source of OP_REG x0 becomes OP_ZERO; a destination of OP_REG x0 becomes OP_INVD.
  - Unknown format: all fields 0 except pc, opcode, valid and SIMID.
- **EBREAK handling**
  - Let k be the lowest valid lane whose uop is U_EBREAK. Lanes 0..k are pushed; lanes above k are dropped.
  - ebreak_hold_de sets at the clock edge after the push.
  - While ebreak_hold_de = 1, accepted bundles are consumed and discarded: decode_ready_de0 still follows queue space and nothing is pushed.
- **Queue**
  - Circular buffer with read and write pointers that wrap modulo DEPTH (DEPTH need not be a power of two).
  - Push count is 0..NDEC per cycle.
  - Pop count = rename_ready_rn0 ? min(occupancy_de, NPOP) : 0.
  - uinstr_de1[i] is the entry at rd_ptr+i, with `.valid` forced to valid_de1[i]. Slots with valid_de1 = 0 drive '0.
  - occupancy_de(next) = occupancy_de + pushes − pops.
- **Nuke**
  - nuke_rb1.valid takes priority over same-cycle pushes and pops.
  - Next cycle: pointers = 0, occupancy_de = 0, ebreak_hold_de = 0.
  - Outputs that cycle are unchanged.

## Timing
- **Reset** (effective at the first edge with reset = 1):
  - occupancy_de = 0, ebreak_hold_de = 0, valid_de1 = 0, uinstr_de1 = '0.
  - decode_ready_de0 = 0 while reset is high; it rises combinationally in the first cycle with reset low.
  - Reset asserted mid-operation discards all queue contents.
- **Latency:** bundle accepted in cycle t → earliest valid_de1 in cycle t+1. There is no DE0→DE1 bypass.
- **Full queue:** decode_ready_de0 follows the registered occupancy only. Same-cycle pops do not raise it, so there is no combinational path from rename_ready_rn0 to decode_ready_de0.
- **Empty queue:** valid_de1 = 0 regardless of rename_ready_rn0.
- **Simultaneous push and pop** at occupancy DEPTH−NDEC both proceed; occupancy updates by the net count.
- **Ordering:** uops pop in strict lane-then-cycle program order across pointer wrap.

## Test plan
- **Single ADD:** reset, then one ADD x3,x1,x2 on lane 0 with rename ready → valid_de1 = 2'b01 next cycle; dst OP_REG x3 SZ_8B; imm64 = 0.
- **ADDI x0 and ADDIW:** lane 0 ADDI x0,x0,-1; lane 1 ADDIW x5,x6,4 → lane 0 decodes dst OP_INVD, src1 OP_ZERO, imm64 = 64'hFFFF_FFFF_FFFF_FFFF; lane 1 decodes opsize SZ_4B, imm64 = 4.
- **Backpressure:** hold rename_ready_rn0 = 0 and stream 2-wide bundles → decode_ready_de0 drops when occupancy_de = 7 (DEPTH 8). Release → 2 uops per cycle drain in order with no loss or duplication across wrap.
- **EBREAK in lane 0:** EBREAK in lane 0, ADD in lane 1 → exactly one uop queued; ebreak_hold_de = 1; later bundles are not queued. Assert nuke_rb1.valid → hold clears and the next bundle is queued.
- **Nuke with simultaneous traffic:** nuke in the same cycle as a push and a pop with occupancy 5 → occupancy_de = 0 next cycle and valid_de1 = 0.
- **Immediate formats:** LUI x1,0x80000 → imm64 = 64'hFFFF_FFFF_8000_0000. JAL with offset −4 → imm64 = −4. SW with offset 2047 → imm64 = 2047.

Source files
------------

// File: rtl/decode_wide.sv
// N-wide decode stage: decodes up to NDEC raw instructions per cycle into uops,
// buffers them in program order and hands up to NPOP per cycle to rename.
package decode_wide_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [31:0] simid;
  } t_instr_pkt;

  typedef struct packed {
    logic        valid;
    logic [31:0] simid;
  } t_nuke_pkt;

  typedef enum logic [2:0] {IF_UNK, IF_R, IF_I, IF_S, IF_B, IF_U, IF_J} t_ifmt;
  typedef enum logic [1:0] {OP_INVD, OP_REG, OP_IMM, OP_ZERO} t_optype;
  typedef enum logic [1:0] {SZ_1B, SZ_2B, SZ_4B, SZ_8B} t_opsize;

  typedef enum logic [4:0] {
    U_INVALID, U_ADD, U_SUB, U_ALU, U_MUL, U_DIV, U_LOAD, U_STORE, U_BRANCH,
    U_LUI, U_AUIPC, U_JAL, U_JALR, U_FENCE, U_ECALL, U_EBREAK, U_CSR
  } t_uop;

  typedef struct packed {
    t_optype    optype;
    t_opsize    opsize;
    logic [4:0] opreg;
  } t_opnd;

  typedef struct packed {
    logic        valid;
    logic [31:0] simid;
    logic [63:0] pc;
    logic [6:0]  opcode;
    t_ifmt       ifmt;
    t_uop        uop;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    t_opnd       dst;
    t_opnd       src1;
    t_opnd       src2;
    logic [63:0] imm64;
  } t_uinstr;

  function automatic t_ifmt get_instr_format(input logic [6:0] opcode);
    t_ifmt f;
    case (opcode)
      7'b0110011, 7'b0111011:                         f = IF_R;
      7'b0010011, 7'b0011011, 7'b0000011,
      7'b1100111, 7'b1110011, 7'b0001111:             f = IF_I;
      7'b0100011:                                     f = IF_S;
      7'b1100011:                                     f = IF_B;
      7'b0110111, 7'b0010111:                         f = IF_U;
      7'b1101111:                                     f = IF_J;
      default:                                        f = IF_UNK;
    endcase
    return f;
  endfunction

  function automatic t_uop rv_instr_to_uop(input logic [31:0] instr);
    t_uop u;
    case (instr[6:0])
      7'b0110011, 7'b0111011: begin
        if (instr[31:25] == 7'b0000001)  u = instr[14] ? U_DIV : U_MUL;
        else if (instr[14:12] == 3'd0)   u = instr[30] ? U_SUB : U_ADD;
        else                             u = U_ALU;
      end
      7'b0010011, 7'b0011011: u = (instr[14:12] == 3'd0) ? U_ADD : U_ALU;
      7'b0000011:             u = U_LOAD;
      7'b0100011:             u = U_STORE;
      7'b1100011:             u = U_BRANCH;
      7'b0110111:             u = U_LUI;
      7'b0010111:             u = U_AUIPC;
      7'b1101111:             u = U_JAL;
      7'b1100111:             u = U_JALR;
      7'b0001111:             u = U_FENCE;
      7'b1110011: begin
        if (instr[14:12] != 3'd0)          u = U_CSR;
        else if (instr == 32'h0010_0073)   u = U_EBREAK;
        else if (instr == 32'h0000_0073)   u = U_ECALL;
        else                               u = U_INVALID;
      end
      default:                u = U_INVALID;
    endcase
    return u;
  endfunction

endpackage

module decode_wide
  import decode_wide_pkg::*;
#(
  parameter int NDEC  = 2,
  parameter int NPOP  = 2,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  t_nuke_pkt                    nuke_rb1,
  input  logic [NDEC-1:0]              valid_fe1,
  input  t_instr_pkt [NDEC-1:0]        instr_fe1,
  output logic                         decode_ready_de0,
  input  logic                         rename_ready_rn0,
  output logic [NPOP-1:0]              valid_de1,
  output t_uinstr [NPOP-1:0]           uinstr_de1,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_de,
  output logic                         ebreak_hold_de
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] t_ptr;
  typedef logic [OW-1:0] t_cnt;

  if (DEPTH < NDEC || DEPTH < NPOP) begin : g_bad_depth
    $error("decode_wide: DEPTH must be >= NDEC and >= NPOP");
  end

  function automatic logic [63:0] sext(input logic [63:0] v, input int unsigned w);
    logic signed [63:0] t;
    t = signed'(v << (64 - w));
    return t >>> (64 - w);
  endfunction

  function automatic t_opnd opnd(input t_optype ty, input t_opsize sz, input logic [4:0] r);
    t_opnd o;
    o.optype = ty;
    o.opsize = sz;
    o.opreg  = r;
    return o;
  endfunction

  // Non-power-of-two DEPTH: wrap explicitly instead of relying on pointer overflow.
  function automatic t_ptr ptr_add(input t_ptr p, input int unsigned n);
    int unsigned s;
    s = 32'(p) + n;
    if (s >= 32'(DEPTH)) s = s - 32'(DEPTH);
    return t_ptr'(s);
  endfunction

  function automatic t_uinstr decode_lane(input t_instr_pkt ip);
    t_uinstr    u;
    logic [6:0] opc;
    t_opsize    alu_sz;
    u        = '0;
    opc      = ip.instr[6:0];
    alu_sz   = opc[3] ? SZ_4B : SZ_8B;
    u.valid  = 1'b1;
    u.simid  = ip.simid;
    u.pc     = ip.pc;
    u.opcode = opc;
    u.ifmt   = get_instr_format(opc);
    u.uop    = rv_instr_to_uop(ip.instr);
    case (u.ifmt)
      IF_R: begin
        u.funct7 = ip.instr[31:25];
        u.funct3 = ip.instr[14:12];
        u.dst    = opnd(OP_REG, alu_sz, ip.instr[11:7]);
        u.src1   = opnd(OP_REG, alu_sz, ip.instr[19:15]);
        u.src2   = opnd(OP_REG, alu_sz, ip.instr[24:20]);
      end
      IF_I: begin
        u.funct3 = ip.instr[14:12];
        if (opc == 7'b0010011 || opc == 7'b0011011) begin
          u.dst  = opnd(OP_REG, alu_sz, ip.instr[11:7]);
          u.src1 = opnd(OP_REG, alu_sz, ip.instr[19:15]);
          u.src2 = opnd(OP_IMM, alu_sz, 5'd0);
        end else begin
          u.dst  = opnd(OP_REG, SZ_8B, ip.instr[11:7]);
          u.src1 = opnd(OP_REG, SZ_8B, ip.instr[19:15]);
        end
        u.imm64 = sext(64'(ip.instr[31:20]), 12);
      end
      IF_S: begin
        u.src1  = opnd(OP_REG, SZ_8B, ip.instr[19:15]);
        u.src2  = opnd(OP_REG, SZ_8B, ip.instr[24:20]);
        u.imm64 = sext(64'({ip.instr[31:25], ip.instr[11:7]}), 12);
      end
      IF_B: begin
        u.src1  = opnd(OP_REG, SZ_4B, ip.instr[19:15]);
        u.src2  = opnd(OP_REG, SZ_4B, ip.instr[24:20]);
        u.imm64 = sext(64'({ip.instr[31], ip.instr[7], ip.instr[30:25],
                            ip.instr[11:8], 1'b0}), 13);
      end
      IF_U: begin
        u.dst   = opnd(OP_REG, SZ_8B, ip.instr[11:7]);
        u.imm64 = sext(64'({ip.instr[31:12], 12'b0}), 32);
      end
      IF_J: begin
        u.dst   = opnd(OP_REG, SZ_8B, ip.instr[11:7]);
        u.imm64 = sext(64'({ip.instr[31], ip.instr[19:12], ip.instr[20],
                            ip.instr[30:21], 1'b0}), 21);
      end
      default: u.uop = U_INVALID;
    endcase
    if (u.src1.optype == OP_REG && u.src1.opreg == 5'd0) u.src1.optype = OP_ZERO;
    if (u.src2.optype == OP_REG && u.src2.opreg == 5'd0) u.src2.optype = OP_ZERO;
    if (u.dst.optype  == OP_REG && u.dst.opreg  == 5'd0) u.dst.optype  = OP_INVD;
    return u;
  endfunction

  t_uinstr          q_mem [DEPTH];
  t_ptr             rd_ptr;
  t_ptr             wr_ptr;
  t_uinstr          dec_p0 [NDEC];
  logic [NDEC-1:0]  push_vld_p0;
  logic             accept_p0;
  logic             ebrk_blk_p0;
  logic             ebrk_push_p0;
  t_cnt             push_cnt_p0;
  t_cnt             pop_cnt;
  logic             nuke_unused;

  assign nuke_unused = ^nuke_rb1.simid;

  // DE0: decode, bundle acceptance, EBREAK truncation
  assign decode_ready_de0 = ~reset & ((t_cnt'(DEPTH) - occupancy_de) >= t_cnt'(NDEC));
  assign accept_p0        = decode_ready_de0 & (|valid_fe1);

  always_comb begin
    for (int i = 0; i < NDEC; i++) dec_p0[i] = decode_lane(instr_fe1[i]);
  end

  always_comb begin
    push_vld_p0  = '0;
    push_cnt_p0  = '0;
    ebrk_blk_p0  = 1'b0;
    ebrk_push_p0 = 1'b0;
    for (int i = 0; i < NDEC; i++) begin
      if (accept_p0 && !ebreak_hold_de && valid_fe1[i] && !ebrk_blk_p0) begin
        push_vld_p0[i] = 1'b1;
        push_cnt_p0    = push_cnt_p0 + t_cnt'(1);
        if (dec_p0[i].uop == U_EBREAK) begin
          ebrk_blk_p0  = 1'b1;
          ebrk_push_p0 = 1'b1;
        end
      end
    end
  end

  // DE1: pop window from the head of the queue
  always_comb begin
    pop_cnt    = '0;
    valid_de1  = '0;
    uinstr_de1 = '0;
    for (int i = 0; i < NPOP; i++) begin
      if (rename_ready_rn0 && (t_cnt'(i) < occupancy_de)) begin
        valid_de1[i]        = 1'b1;
        uinstr_de1[i]       = q_mem[ptr_add(rd_ptr, 32'(i))];
        uinstr_de1[i].valid = 1'b1;
        pop_cnt             = pop_cnt + t_cnt'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || nuke_rb1.valid) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      occupancy_de   <= '0;
      ebreak_hold_de <= 1'b0;
    end else begin
      rd_ptr       <= ptr_add(rd_ptr, 32'(pop_cnt));
      wr_ptr       <= ptr_add(wr_ptr, 32'(push_cnt_p0));
      occupancy_de <= occupancy_de + push_cnt_p0 - pop_cnt;
      if (ebrk_push_p0) ebreak_hold_de <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NDEC; i++) begin
      if (push_vld_p0[i]) q_mem[ptr_add(wr_ptr, 32'(i))] <= dec_p0[i];
    end
  end

endmodule

// File: tb/tb_decode_wide.sv
// Directed bench for decode_wide: decode fields, immediates, backpressure,
// wrap-around ordering, EBREAK hold, nuke and reset.
module tb_decode_wide;
  import decode_wide_pkg::*;

  localparam int NDEC  = 2;
  localparam int NPOP  = 2;
  localparam int DEPTH = 8;

  localparam logic [31:0] I_ADD    = 32'h0020_81B3; // add   x3,x1,x2
  localparam logic [31:0] I_ADDI0  = 32'hFFF0_0013; // addi  x0,x0,-1
  localparam logic [31:0] I_ADDIW  = 32'h0043_029B; // addiw x5,x6,4
  localparam logic [31:0] I_EBREAK = 32'h0010_0073;
  localparam logic [31:0] I_LUI    = 32'h8000_00B7; // lui   x1,0x80000
  localparam logic [31:0] I_JAL    = 32'hFFDF_F0EF; // jal   x1,-4
  localparam logic [31:0] I_SW     = 32'h7E20_AFA3; // sw    x2,2047(x1)

  logic                   clk = 1'b0;
  logic                   reset;
  t_nuke_pkt              nuke_rb1;
  logic [NDEC-1:0]        valid_fe1;
  t_instr_pkt [NDEC-1:0]  instr_fe1;
  logic                   decode_ready_de0;
  logic                   rename_ready_rn0;
  logic [NPOP-1:0]        valid_de1;
  t_uinstr [NPOP-1:0]     uinstr_de1;
  logic [3:0]             occupancy_de;
  logic                   ebreak_hold_de;

  int n_chk  = 0;
  int n_fail = 0;
  logic [63:0] exp_q [$];

  decode_wide #(.NDEC(NDEC), .NPOP(NPOP), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .nuke_rb1         (nuke_rb1),
    .valid_fe1        (valid_fe1),
    .instr_fe1        (instr_fe1),
    .decode_ready_de0 (decode_ready_de0),
    .rename_ready_rn0 (rename_ready_rn0),
    .valid_de1        (valid_de1),
    .uinstr_de1       (uinstr_de1),
    .occupancy_de     (occupancy_de),
    .ebreak_hold_de   (ebreak_hold_de)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push2(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1);
    valid_fe1          = v;
    instr_fe1[0].instr = i0;
    instr_fe1[1].instr = i1;
    tick();
    valid_fe1 = '0;
    #1;
  endtask

  function automatic logic [31:0] addi_x7(input int imm);
    return {12'(imm), 5'd0, 3'd0, 5'd7, 7'h13};
  endfunction

  initial begin
    reset            = 1'b1;
    nuke_rb1         = '0;
    valid_fe1        = '0;
    instr_fe1        = '0;
    rename_ready_rn0 = 1'b0;
    instr_fe1[0].pc    = 64'h1000;
    instr_fe1[1].pc    = 64'h1004;
    instr_fe1[0].simid = 32'd10;
    instr_fe1[1].simid = 32'd11;
    repeat (2) tick();

    chk("rst_occ",   64'(occupancy_de), 64'd0);
    chk("rst_hold",  64'(ebreak_hold_de), 64'd0);
    chk("rst_vld",   64'(valid_de1), 64'd0);
    chk("rst_rdy",   64'(decode_ready_de0), 64'd0);
    chk("rst_uinst", 64'(|uinstr_de1), 64'd0);
    reset = 1'b0;
    #1;
    chk("rdy_after_rst", 64'(decode_ready_de0), 64'd1);

    // single ADD with rename ready; no same-cycle bypass
    rename_ready_rn0 = 1'b1;
    valid_fe1 = 2'b01;
    instr_fe1[0].instr = I_ADD;
    #1;
    chk("add_no_bypass", 64'(valid_de1), 64'd0);
    tick();
    valid_fe1 = '0;
    #1;
    chk("add_vld",     64'(valid_de1), 64'b01);
    chk("add_dst_ty",  64'(uinstr_de1[0].dst.optype), 64'(OP_REG));
    chk("add_dst_reg", 64'(uinstr_de1[0].dst.opreg), 64'd3);
    chk("add_dst_sz",  64'(uinstr_de1[0].dst.opsize), 64'(SZ_8B));
    chk("add_src1",    64'(uinstr_de1[0].src1.opreg), 64'd1);
    chk("add_src2",    64'(uinstr_de1[0].src2.opreg), 64'd2);
    chk("add_imm",     uinstr_de1[0].imm64, 64'd0);
    chk("add_uop",     64'(uinstr_de1[0].uop), 64'(U_ADD));
    chk("add_pc",      uinstr_de1[0].pc, 64'h1000);
    chk("add_slot1",   64'(|uinstr_de1[1]), 64'd0);
    tick();
    chk("add_drained", 64'(occupancy_de), 64'd0);

    // ADDI x0 and ADDIW
    rename_ready_rn0 = 1'b0;
    push2(2'b11, I_ADDI0, I_ADDIW);
    chk("addi_occ", 64'(occupancy_de), 64'd2);
    rename_ready_rn0 = 1'b1;
    #1;
    chk("addi_vld",      64'(valid_de1), 64'b11);
    chk("addi0_dst",     64'(uinstr_de1[0].dst.optype), 64'(OP_INVD));
    chk("addi0_src1",    64'(uinstr_de1[0].src1.optype), 64'(OP_ZERO));
    chk("addi0_src2",    64'(uinstr_de1[0].src2.optype), 64'(OP_IMM));
    chk("addi0_imm",     uinstr_de1[0].imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addiw_sz",      64'(uinstr_de1[1].dst.opsize), 64'(SZ_4B));
    chk("addiw_dst",     64'(uinstr_de1[1].dst.opreg), 64'd5);
    chk("addiw_src1",    64'(uinstr_de1[1].src1.opreg), 64'd6);
    chk("addiw_imm",     uinstr_de1[1].imm64, 64'd4);
    tick();
    rename_ready_rn0 = 1'b0;

    // immediate formats
    push2(2'b11, I_LUI, I_JAL);
    rename_ready_rn0 = 1'b1;
    #1;
    chk("lui_imm",  uinstr_de1[0].imm64, 64'hFFFF_FFFF_8000_0000);
    chk("lui_dst",  64'(uinstr_de1[0].dst.opreg), 64'd1);
    chk("jal_imm",  uinstr_de1[1].imm64, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("jal_uop",  64'(uinstr_de1[1].uop), 64'(U_JAL));
    tick();
    rename_ready_rn0 = 1'b0;
    push2(2'b01, I_SW, 32'd0);
    rename_ready_rn0 = 1'b1;
    #1;
    chk("sw_vld",  64'(valid_de1), 64'b01);
    chk("sw_imm",  uinstr_de1[0].imm64, 64'd2047);
    chk("sw_dst",  64'(uinstr_de1[0].dst.optype), 64'(OP_INVD));
    chk("sw_src2", 64'(uinstr_de1[0].src2.opreg), 64'd2);
    tick();
    rename_ready_rn0 = 1'b0;
    chk("imm_drained", 64'(occupancy_de), 64'd0);

    // backpressure fill to 7 with write pointer mid-buffer
    push2(2'b01, addi_x7(1), 32'd0);
    exp_q.push_back(64'd1);
    for (int c = 0; c < 10; c++) begin
      int seq;
      if (!decode_ready_de0) break;
      seq = 2 * c + 2;
      push2(2'b11, addi_x7(seq), addi_x7(seq + 1));
      exp_q.push_back(64'(seq));
      exp_q.push_back(64'(seq + 1));
    end
    chk("bp_occ", 64'(occupancy_de), 64'd7);
    chk("bp_rdy", 64'(decode_ready_de0), 64'd0);
    push2(2'b11, addi_x7(99), addi_x7(99));
    chk("bp_no_accept", 64'(occupancy_de), 64'd7);

    rename_ready_rn0 = 1'b1;
    for (int c = 0; c < 12 && exp_q.size() > 0; c++) begin
      logic [1:0] vpat;
      #1;
      vpat = (exp_q.size() >= 2) ? 2'b11 : 2'b01;
      chk("drain_vld", 64'(valid_de1), 64'(vpat));
      for (int s = 0; s < NPOP; s++) begin
        if (valid_de1[s]) begin
          if (exp_q.size() == 0) chk("drain_extra", 64'd1, 64'd0);
          else begin
            chk("drain_order", uinstr_de1[s].imm64, exp_q.pop_front());
            chk("drain_ufld_vld", 64'(uinstr_de1[s].valid), 64'd1);
          end
        end
      end
      tick();
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    chk("drain_occ",  64'(occupancy_de), 64'd0);
    #1;
    chk("empty_vld",  64'(valid_de1), 64'd0);
    rename_ready_rn0 = 1'b0;

    // simultaneous push and pop at DEPTH-NDEC
    for (int c = 0; c < 3; c++) push2(2'b11, I_ADD, I_ADD);
    chk("pp_occ_pre", 64'(occupancy_de), 64'd6);
    rename_ready_rn0 = 1'b1;
    valid_fe1 = 2'b11;
    #1;
    chk("pp_rdy", 64'(decode_ready_de0), 64'd1);
    chk("pp_vld", 64'(valid_de1), 64'b11);
    tick();
    valid_fe1 = '0;
    #1;
    chk("pp_occ", 64'(occupancy_de), 64'd6);

    // nuke with a push and a pop at occupancy 5
    tick();
    rename_ready_rn0 = 1'b0;
    push2(2'b01, I_ADD, 32'd0);
    chk("nk_occ_pre", 64'(occupancy_de), 64'd5);
    nuke_rb1.valid   = 1'b1;
    rename_ready_rn0 = 1'b1;
    valid_fe1        = 2'b11;
    #1;
    chk("nk_vld_same", 64'(valid_de1), 64'b11);
    tick();
    nuke_rb1.valid = 1'b0;
    valid_fe1      = '0;
    #1;
    chk("nk_occ", 64'(occupancy_de), 64'd0);
    chk("nk_vld", 64'(valid_de1), 64'd0);
    rename_ready_rn0 = 1'b0;

    // EBREAK in lane 0 drops lane 1 and holds off later bundles
    push2(2'b11, I_EBREAK, I_ADD);
    chk("eb_occ",  64'(occupancy_de), 64'd1);
    chk("eb_hold", 64'(ebreak_hold_de), 64'd1);
    chk("eb_rdy",  64'(decode_ready_de0), 64'd1);
    push2(2'b11, I_ADD, I_ADD);
    chk("eb_discard", 64'(occupancy_de), 64'd1);
    rename_ready_rn0 = 1'b1;
    #1;
    chk("eb_pop_vld", 64'(valid_de1), 64'b01);
    chk("eb_pop_uop", 64'(uinstr_de1[0].uop), 64'(U_EBREAK));
    tick();
    rename_ready_rn0 = 1'b0;
    chk("eb_hold_kept", 64'(ebreak_hold_de), 64'd1);
    nuke_rb1.valid = 1'b1;
    tick();
    nuke_rb1.valid = 1'b0;
    chk("eb_hold_clr", 64'(ebreak_hold_de), 64'd0);
    push2(2'b01, I_ADD, 32'd0);
    chk("eb_after_nuke", 64'(occupancy_de), 64'd1);

    // EBREAK in lane 1 keeps both lanes
    push2(2'b11, I_ADD, I_EBREAK);
    chk("eb1_occ",  64'(occupancy_de), 64'd3);
    chk("eb1_hold", 64'(ebreak_hold_de), 64'd1);

    // reset mid-operation discards contents
    reset = 1'b1;
    tick();
    chk("mrst_occ",  64'(occupancy_de), 64'd0);
    chk("mrst_hold", 64'(ebreak_hold_de), 64'd0);
    chk("mrst_rdy",  64'(decode_ready_de0), 64'd0);
    reset = 1'b0;
    #1;
    chk("mrst_rdy_rel", 64'(decode_ready_de0), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
